dac_refresh_sched: RTL and testbench



---
 rtl/dac_sched_pkg.sv | 45 ++++
 rtl/rr_arb2.sv | 49 ++++
 rtl/dac_refresh_sched.sv | 181 ++++++++++++++++++
 tb/tb_dac_refresh_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg
//   Shared types and helpers for the DAC refresh scheduler.
//   NCH / DW / AW : channel count, code width, channel address width.
//   state_e       : scheduler FSM states.
//   wr_req_t      : bank write request (req, addr, data).
//   next_dirty()  : round-robin search for the next pending channel.
package dac_sched_pkg;

    localparam int NCH = 8;
    localparam int DW  = 12;
    localparam int AW  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_LOAD,
        S_WAIT_SPI,
        S_SETTLE
    } state_e;

    typedef struct packed {
        logic          req;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    // First set bit of dirty, searching upward from last+1 and wrapping.
    // The last probe (i == NCH) lands on 'last' itself, so a lone pending
    // bit on the previous channel is still found.
    function automatic logic [AW-1:0] next_dirty(input logic [NCH-1:0] dirty,
                                                 input logic [AW-1:0]  last);
        logic [AW-1:0] idx;
        logic          found;
        next_dirty = last;
        found      = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = last + AW'(i);
            if (!found && dirty[idx]) begin
                next_dirty = idx;
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter with registered one-cycle grants.
//   clk, rst          : clock, asynchronous active-high reset.
//   req_a_i, req_b_i  : requests, held until granted.
//   gnt_a_o, gnt_b_o  : one-cycle grant pulses, asserted the cycle after
//                       the request is seen.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic gnt_a_q, gnt_b_q, gnt_a_d, gnt_b_d;
    logic last_b_q, last_b_d;   // 1: B was granted most recently
    logic elig_a, elig_b;

    // A requester still shows req during its grant cycle; masking it for
    // that cycle keeps a single held request from being granted twice.
    assign elig_a = req_a_i & ~gnt_a_q;
    assign elig_b = req_b_i & ~gnt_b_q;

    always_comb begin
        gnt_a_d  = elig_a & (~elig_b | last_b_q);
        gnt_b_d  = elig_b & (~elig_a | ~last_b_q);
        last_b_d = last_b_q;
        if (gnt_b_d)      last_b_d = 1'b1;
        else if (gnt_a_d) last_b_d = 1'b0;
    end

    // last_b resets high so A wins the first contested cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            last_b_q <= 1'b1;
        end else begin
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            last_b_q <= last_b_d;
        end
    end

    assign gnt_a_o = gnt_a_q;
    assign gnt_b_o = gnt_b_q;

endmodule

// File: rtl/dac_refresh_sched.sv
// dac_refresh_sched
//   Holds an 8 x 12-bit DAC code bank written by two requesters and
//   cycles dirty channels through one DAC + HC4051 sample/hold mux.
//   clk, rst                  : clock, asynchronous active-high reset.
//   a_req/a_addr/a_data/a_gnt : requester A write port (UART path).
//   b_req/b_addr/b_data/b_gnt : requester B write port (AR9331 path).
//   refresh_all               : pulse, marks every channel dirty.
//   spi_busy, spi_done        : SPI engine status / end-of-frame pulse.
//   spi_start, spi_data       : frame launch pulse and code for the frame.
//   pos, mux_inh              : HC4051 channel select and inhibit.
//   dirty, idle               : pending flags; idle when nothing pending.
module dac_refresh_sched
    import dac_sched_pkg::*;
#(
    parameter int            SETTLE_CYC  = 16,
    parameter int            REFRESH_CYC = 2_500_000,
    parameter logic [DW-1:0] RST_CODE    = 12'h800
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           a_req,
    input  logic [AW-1:0]  a_addr,
    input  logic [DW-1:0]  a_data,
    output logic           a_gnt,
    input  logic           b_req,
    input  logic [AW-1:0]  b_addr,
    input  logic [DW-1:0]  b_data,
    output logic           b_gnt,
    input  logic           refresh_all,
    input  logic           spi_busy,
    input  logic           spi_done,
    output logic           spi_start,
    output logic [DW-1:0]  spi_data,
    output logic [AW-1:0]  pos,
    output logic           mux_inh,
    output logic [NCH-1:0] dirty,
    output logic           idle
);

    localparam int SETTLE_LAST  = (SETTLE_CYC > 1) ? SETTLE_CYC - 1 : 0;
    localparam int SCW          = (SETTLE_LAST > 0) ? $clog2(SETTLE_LAST + 1) : 1;
    localparam int REFRESH_LAST = (REFRESH_CYC > 1) ? REFRESH_CYC - 1 : 0;
    localparam int RCW          = (REFRESH_LAST > 0) ? $clog2(REFRESH_LAST + 1) : 1;
    localparam bit REFRESH_EN   = (REFRESH_CYC > 0);

    state_e                  state_q, state_d;
    logic [NCH-1:0][DW-1:0]  bank_q;
    logic [NCH-1:0]          dirty_q, dirty_d;
    logic [AW-1:0]           ch_q, ch_d, last_ch_q, last_ch_d;
    logic [SCW-1:0]          settle_cnt_q, settle_cnt_d;
    logic [RCW-1:0]          refr_cnt_q, refr_cnt_d;
    logic [DW-1:0]           spi_data_q, spi_data_d;
    logic [AW-1:0]           pos_q, pos_d;
    logic                    mux_inh_q, mux_inh_d;
    logic                    settle_done, refr_run, refr_expire;
    wr_req_t                 a_wr, b_wr, wr;

    // ---------------- write arbitration ----------------
    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a_i (a_req),
        .req_b_i (b_req),
        .gnt_a_o (a_gnt),
        .gnt_b_o (b_gnt)
    );

    assign a_wr = '{req: a_req, addr: a_addr, data: a_data};
    assign b_wr = '{req: b_req, addr: b_addr, data: b_data};

    // Grant cycle is the commit cycle; wr.req here means "commit now".
    always_comb begin
        wr     = b_wr;
        wr.req = b_gnt;
        if (a_gnt) begin
            wr     = a_wr;
            wr.req = 1'b1;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    assign settle_done = (settle_cnt_q == SCW'(SETTLE_LAST));

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (|dirty_q) state_d = S_SEL;
            S_SEL:      state_d = S_LOAD;
            S_LOAD:     if (!spi_busy) state_d = S_WAIT_SPI;
            S_WAIT_SPI: if (spi_done) state_d = S_SETTLE;
            S_SETTLE:   if (settle_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath next values ----------------
    always_comb begin
        spi_start    = 1'b0;
        ch_d         = ch_q;
        last_ch_d    = last_ch_q;
        settle_cnt_d = settle_cnt_q;
        spi_data_d   = spi_data_q;
        pos_d        = pos_q;
        mux_inh_d    = mux_inh_q;
        case (state_q)
            S_SEL: ch_d = next_dirty(dirty_q, last_ch_q);
            S_LOAD: begin
                if (!spi_busy) begin
                    spi_start  = 1'b1;
                    spi_data_d = bank_q[ch_q];
                    mux_inh_d  = 1'b1;
                end
            end
            S_WAIT_SPI: begin
                if (spi_done) begin
                    pos_d        = ch_q;
                    mux_inh_d    = 1'b0;
                    settle_cnt_d = '0;
                end
            end
            S_SETTLE: begin
                if (settle_done) last_ch_d = ch_q;
                else             settle_cnt_d = settle_cnt_q + SCW'(1);
            end
            default: ;
        endcase
    end

    // ---------------- dirty flags and periodic refresh ----------------
    assign refr_run    = (state_q == S_IDLE) && (dirty_q == '0);
    assign refr_expire = REFRESH_EN && refr_run && (refr_cnt_q == RCW'(REFRESH_LAST));
    assign refr_cnt_d  = (refr_run && !refr_expire) ? refr_cnt_q + RCW'(1) : '0;

    // Clear first, then set: a same-cycle write or refresh wins over the
    // clear so the channel is picked up again on a later pass.
    always_comb begin
        dirty_d = dirty_q;
        if (spi_start)                  dirty_d[ch_q]    = 1'b0;
        if (wr.req)                     dirty_d[wr.addr] = 1'b1;
        if (refresh_all || refr_expire) dirty_d          = '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) bank_q[i] <= RST_CODE;
            dirty_q      <= '1;
            ch_q         <= '0;
            last_ch_q    <= AW'(NCH - 1);
            settle_cnt_q <= '0;
            refr_cnt_q   <= '0;
            spi_data_q   <= '0;
            pos_q        <= '0;
            mux_inh_q    <= 1'b1;
        end else begin
            if (wr.req) bank_q[wr.addr] <= wr.data;
            dirty_q      <= dirty_d;
            ch_q         <= ch_d;
            last_ch_q    <= last_ch_d;
            settle_cnt_q <= settle_cnt_d;
            refr_cnt_q   <= refr_cnt_d;
            spi_data_q   <= spi_data_d;
            pos_q        <= pos_d;
            mux_inh_q    <= mux_inh_d;
        end
    end

    // In LOAD the live bank value is presented so spi_data is already valid
    // in the spi_start cycle; the latched copy holds it for the frame.
    assign spi_data = (state_q == S_LOAD) ? bank_q[ch_q] : spi_data_q;
    assign pos      = pos_q;
    assign mux_inh  = mux_inh_q;
    assign dirty    = dirty_q;
    assign idle     = refr_run;

endmodule

// File: tb/tb_dac_refresh_sched.sv
module tb_dac_refresh_sched;

    localparam int FRAME = 20;

    logic        clk, rst;
    logic        a_req, b_req, a_gnt, b_gnt;
    logic [2:0]  a_addr, b_addr, pos;
    logic [11:0] a_data, b_data, spi_data;
    logic        refresh_all, spi_busy, spi_done, spi_start, mux_inh, idle;
    logic [7:0]  dirty;

    bit          force_busy;
    int          start_cnt;
    int          chq[$];
    logic [11:0] dq[$];
    int          n_chk, n_pass;

    dac_refresh_sched #(
        .SETTLE_CYC  (16),
        .REFRESH_CYC (100),
        .RST_CODE    (12'h800)
    ) dut (
        .clk (clk), .rst (rst),
        .a_req (a_req), .a_addr (a_addr), .a_data (a_data), .a_gnt (a_gnt),
        .b_req (b_req), .b_addr (b_addr), .b_data (b_data), .b_gnt (b_gnt),
        .refresh_all (refresh_all),
        .spi_busy (spi_busy), .spi_done (spi_done),
        .spi_start (spi_start), .spi_data (spi_data),
        .pos (pos), .mux_inh (mux_inh), .dirty (dirty), .idle (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SPI engine model plus frame/channel monitor.
    int cnt;
    bit pend, prev_inh;
    initial begin
        cnt = 0; pend = 0; prev_inh = 1;
        spi_busy = 0; spi_done = 0; start_cnt = 0;
        forever begin
            @(negedge clk); #2;
            spi_done = 0;
            if (rst) begin
                cnt = 0; pend = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) spi_done = 1;
                end
                if (pend) begin cnt = FRAME; pend = 0; end
            end
            spi_busy = force_busy || (cnt > 0);
            #1;
            if (spi_start && !rst) begin
                pend = 1;
                start_cnt++;
                dq.push_back(spi_data);
            end
            if (prev_inh && !mux_inh) chq.push_back(int'(pos));
            prev_inh = mux_inh;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic wait_frames(input int n, input int bound);
        int k;
        k = 0;
        while (chq.size() < n && k < bound) begin @(negedge clk); k++; end
        chk("frame_count", chq.size(), n);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!idle && cyc < 400);
        chk("idle_reached", idle, 1);
    endtask

    task automatic do_write(input bit use_b, input logic [2:0] ad, input logic [11:0] d);
        int k;
        if (use_b) begin b_req = 1; b_addr = ad; b_data = d; end
        else       begin a_req = 1; a_addr = ad; a_data = d; end
        k = 0;
        do begin @(negedge clk); k++; end while (!(use_b ? b_gnt : a_gnt) && k < 8);
        chk(use_b ? "b_gnt_latency" : "a_gnt_latency", k, 1);
        a_req = 0; b_req = 0;
    endtask

    int s0, cyc;
    int          exp_ch[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    logic [11:0] exp_d[9]  = '{12'h0AB, 12'd1024, 12'd900, 12'h800, 12'd1536,
                               12'h123, 12'h800, 12'h800, 12'h0AB};

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1; force_busy = 0; refresh_all = 0;
        a_req = 0; a_addr = 0; a_data = 0;
        b_req = 0; b_addr = 0; b_data = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_dirty", dirty, 8'hFF);
        chk("rst_mux_inh", mux_inh, 1);
        chk("rst_pos", pos, 0);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_spi_data", spi_data, 0);
        chk("rst_idle", idle, 0);
        chk("rst_gnts", {a_gnt, b_gnt}, 2'b00);
        rst = 0;

        // Post-reset sweep: channels 0..7 with the reset code
        wait_frames(8, 600);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sweep_ch%0d", i), chq[i], i);
            chk($sformatf("sweep_data%0d", i), dq[i], 12'h800);
        end
        // monitor lags the first SETTLE cycle by one, so 16 settle cycles -> 15
        wait_idle(cyc);
        chk("settle_to_idle", cyc, 15);

        // Periodic refresh fires exactly 100 cycles after idle rises
        repeat (99) @(negedge clk);
        chk("refr_before", dirty, 8'h00);
        @(negedge clk);
        chk("refr_expire", dirty, 8'hFF);
        chq.delete(); dq.delete();
        wait_frames(8, 600);
        chk("refr_sweep_first", chq[0], 0);
        chk("refr_sweep_last", chq[7], 7);
        wait_idle(cyc);

        // A and B together: A first, B next cycle
        chq.delete(); dq.delete();
        a_req = 1; a_addr = 3; a_data = 12'd900;
        b_req = 1; b_addr = 5; b_data = 12'd1536;
        @(negedge clk);
        chk("ab_first", {a_gnt, b_gnt}, 2'b10);
        a_req = 0;
        @(negedge clk);
        chk("ab_second", {a_gnt, b_gnt}, 2'b01);
        b_req = 0;
        @(negedge clk);
        chk("ab_quiet", {a_gnt, b_gnt}, 2'b00);
        wait_frames(2, 200);
        chk("ab_ch0", chq[0], 3);
        chk("ab_d0", dq[0], 12'd900);
        chk("ab_ch1", chq[1], 5);
        chk("ab_d1", dq[1], 12'd1536);
        wait_idle(cyc);

        // spi_busy held 50 cycles in LOAD
        chq.delete(); dq.delete();
        force_busy = 1;
        do_write(1'b1, 3'd6, 12'h123);
        s0 = start_cnt;
        repeat (50) @(negedge clk);
        chk("busy_no_start", start_cnt - s0, 0);
        force_busy = 0;
        repeat (5) @(negedge clk);
        chk("busy_one_start", start_cnt - s0, 1);
        wait_frames(1, 200);
        wait_idle(cyc);
        chk("busy_still_one", start_cnt - s0, 1);
        chk("busy_ch", chq[0], 6);
        chk("busy_data", dq[0], 12'h123);

        // Write ch2 in the same cycle LOAD clears dirty[2]
        chq.delete(); dq.delete();
        force_busy = 1;
        do_write(1'b0, 3'd2, 12'd500);
        repeat (6) @(negedge clk);
        a_req = 1; a_addr = 2; a_data = 12'd1024;
        @(negedge clk);
        chk("race_gnt", a_gnt, 1);
        force_busy = 0;
        #4;
        chk("race_start", spi_start, 1);
        a_req = 0;
        @(negedge clk);
        chk("race_dirty2", dirty[2], 1);
        wait_frames(2, 200);
        chk("race_ch0", chq[0], 2);
        chk("race_d0", dq[0], 12'd500);
        chk("race_ch1", chq[1], 2);
        chk("race_d1", dq[1], 12'd1024);
        wait_idle(cyc);

        // refresh_all during WAIT_SPI re-services every channel
        chq.delete(); dq.delete();
        s0 = start_cnt;
        do_write(1'b0, 3'd1, 12'h0AB);
        for (int k = 0; k < 20 && start_cnt == s0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        refresh_all = 1;
        @(negedge clk);
        refresh_all = 0;
        chk("ra_dirty", dirty, 8'hFF);
        wait_frames(9, 800);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("ra_ch%0d", i), chq[i], exp_ch[i]);
            chk($sformatf("ra_d%0d", i), dq[i], exp_d[i]);
        end
        wait_idle(cyc);

        // Reset in WAIT_SPI on ch4
        s0 = start_cnt;
        do_write(1'b0, 3'd4, 12'h444);
        for (int k = 0; k < 20 && start_cnt == s0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("mid_pos_before", pos, 1);
        rst = 1;
        #1;
        chk("mid_mux_inh", mux_inh, 1);
        chk("mid_pos", pos, 0);
        chk("mid_dirty", dirty, 8'hFF);
        repeat (2) @(negedge clk);
        chq.delete(); dq.delete();
        rst = 0;
        wait_frames(1, 200);
        chk("mid_first_ch", chq[0], 0);
        chk("mid_first_data", dq[0], 12'h800);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
